// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one 8N1 serial transmit line among N_REQ byte requesters. A
// round-robin arbiter picks one requester while the line is idle and latches
// its byte. A single FSM then serialises the frame: start bit, 8 data bits
// LSB first, stop bit. Each bit lasts CLKS_PER_BIT clock cycles.
//
// Ports
//   CLK     in   1              system clock, all logic on rising edge
//   RST     in   1              synchronous active-high reset
//   REQ     in   N_REQ          per-requester request, held until its GNT bit
//   DATA    in   N_REQ*DATA_W   flattened bytes, requester i at [i*8+7:i*8]
//   GNT     out  N_REQ          one-hot, one-cycle pulse on the latching edge
//   BUSY    out  1              high from start bit through stop bit
//   DONE    out  1              one-cycle pulse after the stop bit
//   TX_OUT  out  1              serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          REQ,
    input  logic [N_REQ*DATA_W-1:0]   DATA,
    output logic [N_REQ-1:0]          GNT,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      TX_OUT
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = $clog2(N_REQ);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [N_REQ-1:0]  GNT_ONE   = N_REQ'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              state_r;
    logic [BAUD_W-1:0]   baud_r;
    logic [2:0]          bit_r;
    logic [DATA_W-1:0]   shift_r;
    logic [PTR_W-1:0]    ptr_r;

    logic [PTR_W-1:0]    winner_s;
    logic [DATA_W-1:0]   win_byte_s;
    logic                baud_end_s;

    // First set request bit at or above the pointer, wrapping to 0. The loop
    // runs from the farthest candidate back to the nearest so that the last
    // assignment made is the nearest set bit.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req_vec,
        input logic [PTR_W-1:0] start_ptr
    );
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] pick;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx  = PTR_W'((int'(start_ptr) + k) % N_REQ);
            pick = req_vec[idx] ? idx : pick;
        end
        return pick;
    endfunction

    // Round-robin winner and the byte it offers.
    always_comb begin
        winner_s   = rr_pick(REQ, ptr_r);
        win_byte_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_byte_s = (winner_s == PTR_W'(i)) ? DATA[i*DATA_W +: DATA_W] : win_byte_s;
        end
    end

    assign baud_end_s = (baud_r == BAUD_LAST);

    // Arbitration, frame FSM, baud/bit counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shift_r <= '0;
            ptr_r   <= '0;
            GNT     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            TX_OUT  <= 1'b1;
        end else begin
            // GNT and DONE are single-cycle pulses unless re-asserted below.
            GNT  <= '0;
            DONE <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    baud_r <= '0;
                    bit_r  <= 3'd0;
                    if (|REQ) begin
                        GNT     <= GNT_ONE << winner_s;
                        shift_r <= win_byte_s;
                        ptr_r   <= (winner_s == PTR_LAST) ? '0 : winner_s + PTR_ONE;
                        state_r <= ST_START;
                        TX_OUT  <= 1'b0;
                        BUSY    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        TX_OUT  <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_r  <= '0;
                        bit_r   <= 3'd0;
                        state_r <= ST_DATA;
                        TX_OUT  <= shift_r[0];
                    end else begin
                        baud_r  <= baud_r + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_r <= '0;
                        if (bit_r == 3'd7) begin
                            state_r <= ST_STOP;
                            TX_OUT  <= 1'b1;
                        end else begin
                            // Shift so the next bit to send is always shift_r[0].
                            bit_r   <= bit_r + 3'd1;
                            shift_r <= {1'b0, shift_r[DATA_W-1:1]};
                            TX_OUT  <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_r  <= '0;
                        state_r <= ST_IDLE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        TX_OUT  <= 1'b1;
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    baud_r  <= '0;
                    bit_r   <= 3'd0;
                    BUSY    <= 1'b0;
                    TX_OUT  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Self-checking bench for uart_tx_scheduler (N_REQ=4, CLKS_PER_BIT=4).
// A frame-level reference model tracks the round-robin pointer and the
// position within the current frame. It derives the expected line level from
// that position arithmetically. Directed scenarios run first, then random
// requesters with occasional resets.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int N_REQ = 4;
    localparam int CPB   = 4;
    localparam int DW    = 8;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [N_REQ-1:0]      REQ;
    logic [N_REQ*DW-1:0]   DATA;
    logic [N_REQ-1:0]      GNT;
    logic                  BUSY;
    logic                  DONE;
    logic                  TX_OUT;

    logic [7:0]            dbyte [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign DATA[g*DW +: DW] = dbyte[g];
    end

    always #5 CLK = ~CLK;

    uart_tx_scheduler #(.N_REQ(N_REQ), .CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .DATA   (DATA),
        .GNT    (GNT),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .TX_OUT (TX_OUT)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: frame in flight, cycles since grant, byte, pointer.
    bit               m_active = 1'b0;
    int               m_pos    = 0;
    logic [7:0]       m_byte   = 8'h00;
    int               m_ptr    = 0;
    logic [N_REQ-1:0] m_gnt    = '0;
    bit               m_done   = 1'b0;

    logic             cap_rst;
    logic [N_REQ-1:0] cap_req;
    logic [7:0]       cap_d [N_REQ];

    int cyc = 0;
    int g_idx[$];
    int g_cyc[$];

    task automatic model_edge();
        int w;
        w      = -1;
        m_gnt  = '0;
        m_done = 1'b0;
        if (cap_rst) begin
            m_active = 1'b0;
            m_ptr    = 0;
        end else if (m_active) begin
            m_pos++;
            if (m_pos == 10*CPB) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (cap_req != '0) begin
            for (int k = 0; k < N_REQ; k++)
                if (w < 0 && cap_req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
            m_gnt[w] = 1'b1;
            m_byte   = cap_d[w];
            m_ptr    = (w + 1) % N_REQ;
            m_active = 1'b1;
            m_pos    = 0;
        end
    endtask

    function automatic logic exp_tx();
        if (!m_active)          return 1'b1;
        else if (m_pos < CPB)   return 1'b0;
        else if (m_pos < 9*CPB) return m_byte[(m_pos - CPB) / CPB];
        else                    return 1'b1;
    endfunction

    // One clock: capture the inputs the DUT will sample, advance the model, compare.
    task automatic step();
        cap_rst = RST;
        cap_req = REQ;
        for (int i = 0; i < N_REQ; i++) cap_d[i] = dbyte[i];
        @(posedge CLK);
        #1;
        cyc++;
        model_edge();
        chk("gnt",  32'(GNT),    32'(m_gnt));
        chk("busy", 32'(BUSY),   32'(m_active));
        chk("done", 32'(DONE),   32'(m_done));
        chk("tx",   32'(TX_OUT), 32'(exp_tx()));
        for (int i = 0; i < N_REQ; i++) begin
            if (GNT[i]) begin
                g_idx.push_back(i);
                g_cyc.push_back(cyc);
            end
        end
    endtask

    // Requesters drop REQ the cycle after their grant and then change their
    // byte; in random mode they also raise, withdraw and reset at random.
    task automatic run(input int n, input bit rnd);
        for (int c = 0; c < n; c++) begin
            step();
            RST = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                if (GNT[i]) begin
                    REQ[i]   = 1'b0;
                    dbyte[i] = rnd ? 8'($urandom) : 8'hFF;
                end else if (rnd) begin
                    if (!REQ[i] && $urandom_range(0, 15) == 0) begin
                        dbyte[i] = 8'($urandom);
                        REQ[i]   = 1'b1;
                    end else if (REQ[i] && $urandom_range(0, 63) == 0) begin
                        REQ[i] = 1'b0;
                    end
                end
            end
            if (rnd && $urandom_range(0, 499) == 0) RST = 1'b1;
        end
    endtask

    function automatic int qget(input int i);
        return (i < g_idx.size()) ? g_idx[i] : -1;
    endfunction

    function automatic int qgap(input int i);
        return (i + 1 < g_cyc.size()) ? (g_cyc[i+1] - g_cyc[i]) : -1;
    endfunction

    initial begin
        RST = 1'b1;
        REQ = '0;
        for (int i = 0; i < N_REQ; i++) dbyte[i] = 8'h00;

        // Reset state, then a single 0xA5 frame from requester 0.
        run(1, 1'b0);
        dbyte[0] = 8'hA5;
        REQ      = 4'b0001;
        run(45, 1'b0);
        chk("single_n", 32'(g_idx.size()), 32'd1);
        chk("single_w", 32'(qget(0)), 32'd0);

        // All four requesting from pointer 0: order 0,1,2,3, 41 cycles apart.
        RST = 1'b1;
        run(1, 1'b0);
        g_idx.delete(); g_cyc.delete();
        for (int i = 0; i < N_REQ; i++) dbyte[i] = 8'(8'h11 * (i + 1));
        REQ = 4'b1111;
        run(4*41 + 5, 1'b0);
        for (int i = 0; i < N_REQ; i++) chk("rr_order", 32'(qget(i)), 32'(i));
        for (int i = 0; i < N_REQ - 1; i++) chk("rr_gap", 32'(qgap(i)), 32'd41);

        // Pointer at 3 after granting 2; REQ=1001 gives 3 then 0.
        RST = 1'b1;
        run(1, 1'b0);
        g_idx.delete(); g_cyc.delete();
        dbyte[2] = 8'h5A;
        REQ      = 4'b0100;
        run(45, 1'b0);
        dbyte[0] = 8'hC3; dbyte[3] = 8'h81;
        REQ      = 4'b1001;
        run(90, 1'b0);
        chk("wrap_first",  32'(qget(1)), 32'd3);
        chk("wrap_second", 32'(qget(2)), 32'd0);

        // Byte changed to 0xFF right after grant must still go out as 0x3C.
        g_idx.delete(); g_cyc.delete();
        dbyte[1] = 8'h3C;
        REQ      = 4'b0010;
        run(45, 1'b0);
        chk("ignore_w", 32'(qget(0)), 32'd1);

        // Withdrawal: REQ[2] raised for 5 cycles while busy, never granted.
        g_idx.delete(); g_cyc.delete();
        dbyte[0] = 8'h96;
        REQ      = 4'b0001;
        run(3, 1'b0);
        REQ[2] = 1'b1;
        run(5, 1'b0);
        REQ[2] = 1'b0;
        run(45, 1'b0);
        chk("withdraw_n", 32'(g_idx.size()), 32'd1);

        // Reset at data bit 3, then REQ=0110 from pointer 0 grants requester 1.
        g_idx.delete(); g_cyc.delete();
        dbyte[0] = 8'hE7;
        REQ      = 4'b0001;
        run(17, 1'b0);
        RST = 1'b1;
        run(1, 1'b0);
        chk("rst_busy", 32'(BUSY),   32'd0);
        chk("rst_tx",   32'(TX_OUT), 32'd1);
        REQ = 4'b0110;
        run(45, 1'b0);
        chk("rst_regrant", 32'(qget(1)), 32'd1);

        // Random requesters against the model.
        REQ = '0;
        run(45, 1'b0);
        run(4000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
